tdc_power_seq: RTL and testbench
================================

Name: tdc_power_seq

Overview:
- Parametrised TDC power/reset sequencer driven by single-byte UART commands from the rx decoder.
- Drives N_CH per-channel TDC enable and soft-reset lines through a guaranteed low→high enable edge, a boot wait and a multi-cycle soft-reset pulse.
- Adds a per-channel mask, a reset-only command, pause and go-home flags, and ready/busy status.
- Sits between the UART receiver and the per-channel TDC SPI controllers.

Parameters:
- N_CH, 6, number of TDC channels (1..8).
- OFF_CYCLES, 1000, cycles enable is held low before power-up (≥1).
- BOOT_CYCLES, 1000000, cycles enable is held high before soft reset (≥1); covers the 1.7 ms TDC boot.
- RST_PULSE_CYCLES, 4, soft-reset pulse width in cycles (≥1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- rx_data  input  8  received byte.
- new_rx_data  input  1  one-cycle strobe; rx_data valid.
- tdc_enable  output  N_CH  per-channel TDC ENABLE.
- soft_reset  output  N_CH  per-channel soft-reset request, level for RST_PULSE_CYCLES.
- go_home  output  1  home request to motor control.
- pause  output  1  acquisition pause.
- busy  output  1  sequence in progress (OFF, BOOT or SRST).
- ready  output  1  sequence completed; channels up.
- active_mask  output  N_CH  mask latched for the current or last sequence.

Behaviour:
- Reset values: tdc_enable=0, soft_reset=0, go_home=0, pause=0, busy=0, ready=0, state=IDLE, pending mask argument cleared, cfg_mask=all ones, active_mask=all ones, counter=0.
- Counter width is clog2 of the largest of OFF_CYCLES, BOOT_CYCLES, RST_PULSE_CYCLES, plus 1. The counter loads 0 on each state entry and never wraps.
- States and transitions:
  - IDLE: all outputs low except the flags.
  - OFF: enable held low for OFF_CYCLES cycles, then → BOOT.
  - BOOT: tdc_enable=active_mask for BOOT_CYCLES cycles, then → SRST.
  - SRST: tdc_enable=active_mask, soft_reset=active_mask for RST_PULSE_CYCLES cycles, then → READY.
  - READY: tdc_enable=active_mask, ready=1.
- busy = state is OFF, BOOT or SRST. All outputs are registered.
- Commands are acted on only at a cycle where new_rx_data=1:
  - "d": latch active_mask←cfg_mask, clear go_home, → OFF. This restarts from OFF even if a sequence is mid-way.
  - "r": if state is READY → SRST (counter 0); otherwise ignored.
  - "h": go_home←1, → IDLE (aborts any state, enables drop the next cycle).
  - "s": pause←1. "p": pause←0. Neither command affects the sequence.
  - "m": set pending flag. The next strobed byte, of any value, is taken as the mask: cfg_mask←rx_data[N_CH-1:0]. That byte is not decoded as a command, and the pending flag is then cleared. A new mask takes effect only at the next "d".
  - Any other byte is ignored.
- Latency: a strobe at clock edge T changes registers at T+1 and the outputs reflect it from T+1.
  - After "d", the enables are low for exactly OFF_CYCLES cycles and high from cycle OFF_CYCLES+1.
  - soft_reset is high from cycle OFF_CYCLES+BOOT_CYCLES+1 for RST_PULSE_CYCLES cycles.
  - ready rises the cycle after soft_reset falls.
- cfg_mask=0 with "d": the sequence runs with all enables and soft resets held low, and ready asserts normally.
- rst asserted mid-sequence: all outputs return to reset values at the next edge. A pending mask argument is discarded.

Test Plan (OFF_CYCLES=3, BOOT_CYCLES=10, RST_PULSE_CYCLES=2, N_CH=6):
- Reset, then "d" strobe at T → tdc_enable=0 for T+1..T+3; tdc_enable=6'h3F from T+4; soft_reset=6'h3F at T+14..T+15; ready=1 from T+16, busy=0.
- "m", 8'h05, then "d" → active_mask=6'h05; only bits 0 and 2 toggle enable and soft_reset; other channels stay 0.
- "m" then byte "h" (8'h68) → cfg_mask=6'h28; go_home stays 0; state unchanged.
- "h" during BOOT at count 5 → go_home=1, tdc_enable=0, busy=0 next cycle; a following "d" clears go_home and completes the full sequence.
- In READY, "r" → soft_reset high for exactly 2 cycles, enables stay high, ready drops then returns; "r" sent in IDLE → no change.
- "s" then "p" interleaved with a running sequence → pause 1 then 0, sequence timing unaltered; rst during SRST → all outputs 0 and cfg_mask=6'h3F next cycle.

Source files
------------

// File: rtl/tdc_power_seq.sv
// Power/reset sequencer for N_CH TDC channels, commanded by single UART bytes.
// Walks each enabled channel through enable-off, boot wait and a soft-reset pulse.
module tdc_power_seq #(
    parameter int N_CH             = 6,
    parameter int OFF_CYCLES       = 1000,
    parameter int BOOT_CYCLES      = 1000000,
    parameter int RST_PULSE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            new_rx_data,
    output logic [N_CH-1:0] tdc_enable,
    output logic [N_CH-1:0] soft_reset,
    output logic            go_home,
    output logic            pause,
    output logic            busy,
    output logic            ready,
    output logic [N_CH-1:0] active_mask
);

    // state | meaning
    // IDLE  | channels off, waiting for a "d" command
    // OFF   | enables held low to guarantee a clean low->high edge
    // BOOT  | enables high, waiting out the TDC boot time
    // SRST  | enables high, soft-reset pulse asserted
    // READY | sequence complete, channels running
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OFF   = 3'd1,
        BOOT  = 3'd2,
        SRST  = 3'd3,
        READY = 3'd4
    } state_t;

    localparam int MAX_A    = (OFF_CYCLES > BOOT_CYCLES) ? OFF_CYCLES : BOOT_CYCLES;
    localparam int MAX_CYC  = (MAX_A > RST_PULSE_CYCLES) ? MAX_A : RST_PULSE_CYCLES;
    localparam int CNT_W    = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SRST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [7:0] CMD_D = 8'h64;
    localparam logic [7:0] CMD_R = 8'h72;
    localparam logic [7:0] CMD_H = 8'h68;
    localparam logic [7:0] CMD_S = 8'h73;
    localparam logic [7:0] CMD_P = 8'h70;
    localparam logic [7:0] CMD_M = 8'h6d;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mask_pend_q, mask_pend_d;
    logic [N_CH-1:0]   cfg_mask_q, cfg_mask_d;
    logic [N_CH-1:0]   active_mask_q, active_mask_d;
    logic [N_CH-1:0]   tdc_enable_q, tdc_enable_d;
    logic [N_CH-1:0]   soft_reset_q, soft_reset_d;
    logic              go_home_q, go_home_d;
    logic              pause_q, pause_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              enter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mask_pend_q   <= 1'b0;
            cfg_mask_q    <= '1;
            active_mask_q <= '1;
            tdc_enable_q  <= '0;
            soft_reset_q  <= '0;
            go_home_q     <= 1'b0;
            pause_q       <= 1'b0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mask_pend_q   <= mask_pend_d;
            cfg_mask_q    <= cfg_mask_d;
            active_mask_q <= active_mask_d;
            tdc_enable_q  <= tdc_enable_d;
            soft_reset_q  <= soft_reset_d;
            go_home_q     <= go_home_d;
            pause_q       <= pause_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mask_pend_d   = mask_pend_q;
        cfg_mask_d    = cfg_mask_q;
        active_mask_d = active_mask_q;
        go_home_d     = go_home_q;
        pause_d       = pause_q;
        enter         = 1'b0;

        case (state_q)
            OFF:  if (cnt_q == OFF_LAST)  begin state_d = BOOT;  enter = 1'b1; end
            BOOT: if (cnt_q == BOOT_LAST) begin state_d = SRST;  enter = 1'b1; end
            SRST: if (cnt_q == SRST_LAST) begin state_d = READY; enter = 1'b1; end
            default: ;
        endcase

        // A command overrides any timed transition in the same cycle.
        if (new_rx_data) begin
            if (mask_pend_q) begin
                cfg_mask_d  = rx_data[N_CH-1:0];
                mask_pend_d = 1'b0;
            end else begin
                case (rx_data)
                    CMD_D: begin
                        active_mask_d = cfg_mask_q;
                        go_home_d     = 1'b0;
                        state_d       = OFF;
                        enter         = 1'b1;
                    end
                    CMD_R: begin
                        if (state_q == READY) begin
                            state_d = SRST;
                            enter   = 1'b1;
                        end
                    end
                    CMD_H: begin
                        go_home_d = 1'b1;
                        state_d   = IDLE;
                        enter     = 1'b1;
                    end
                    CMD_S:   pause_d     = 1'b1;
                    CMD_P:   pause_d     = 1'b0;
                    CMD_M:   mask_pend_d = 1'b1;
                    default: ;
                endcase
            end
        end

        if (enter) begin
            cnt_d = '0;
        end else if ((state_q == OFF || state_q == BOOT || state_q == SRST) && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they are registered without a cycle of lag.
    always_comb begin
        tdc_enable_d = '0;
        soft_reset_d = '0;
        busy_d       = 1'b0;
        ready_d      = 1'b0;
        case (state_d)
            OFF: busy_d = 1'b1;
            BOOT: begin
                tdc_enable_d = active_mask_d;
                busy_d       = 1'b1;
            end
            SRST: begin
                tdc_enable_d = active_mask_d;
                soft_reset_d = active_mask_d;
                busy_d       = 1'b1;
            end
            READY: begin
                tdc_enable_d = active_mask_d;
                ready_d      = 1'b1;
            end
            default: ;
        endcase
    end

    assign tdc_enable  = tdc_enable_q;
    assign soft_reset  = soft_reset_q;
    assign go_home     = go_home_q;
    assign pause       = pause_q;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign active_mask = active_mask_q;

endmodule

// File: tb/tb_tdc_power_seq.sv
// Directed bench for tdc_power_seq with short timing parameters (OFF=3, BOOT=10, SRST=2).
module tb_tdc_power_seq;

    localparam int N_CH = 6;

    logic            clk;
    logic            rst;
    logic [7:0]      rx_data;
    logic            new_rx_data;
    logic [N_CH-1:0] tdc_enable;
    logic [N_CH-1:0] soft_reset;
    logic            go_home;
    logic            pause;
    logic            busy;
    logic            ready;
    logic [N_CH-1:0] active_mask;

    int n_chk  = 0;
    int n_pass = 0;

    tdc_power_seq #(
        .N_CH(N_CH), .OFF_CYCLES(3), .BOOT_CYCLES(10), .RST_PULSE_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tdc_enable(tdc_enable), .soft_reset(soft_reset), .go_home(go_home),
        .pause(pause), .busy(busy), .ready(ready), .active_mask(active_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; byte is captured at the next posedge, returns one negedge later (spec cycle T+1).
    task automatic send(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
        rx_data     = 8'h00;
    endtask

    task automatic chk_outs(input string tag, input logic [5:0] en, input logic [5:0] sr,
                            input logic bz, input logic rd);
        chk({tag, ".en"},    32'(tdc_enable), 32'(en));
        chk({tag, ".srst"},  32'(soft_reset), 32'(sr));
        chk({tag, ".busy"},  32'(busy),       32'(bz));
        chk({tag, ".ready"}, 32'(ready),      32'(rd));
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; new_rx_data = 1'b0;
        step(3);
        rst = 1'b0;
        chk_outs("reset", 6'h00, 6'h00, 1'b0, 1'b0);
        chk("reset.mask",  32'(active_mask), 32'h3F);
        chk("reset.home",  32'(go_home), 0);
        chk("reset.pause", 32'(pause),   0);

        // Full sequence with default mask.
        send("d");                                     // T+1
        chk_outs("d.t1", 6'h00, 6'h00, 1'b1, 1'b0);
        step(2);                                       // T+3
        chk_outs("d.t3", 6'h00, 6'h00, 1'b1, 1'b0);
        step(1);                                       // T+4
        chk_outs("d.t4", 6'h3F, 6'h00, 1'b1, 1'b0);
        step(9);                                       // T+13
        chk_outs("d.t13", 6'h3F, 6'h00, 1'b1, 1'b0);
        step(1);                                       // T+14
        chk_outs("d.t14", 6'h3F, 6'h3F, 1'b1, 1'b0);
        step(1);
        chk_outs("d.t15", 6'h3F, 6'h3F, 1'b1, 1'b0);
        step(1);
        chk_outs("d.t16", 6'h3F, 6'h00, 1'b0, 1'b1);

        // Mask 0x05.
        send("m"); send(8'h05);
        chk_outs("m05.hold", 6'h3F, 6'h00, 1'b0, 1'b1);
        send("d");
        chk("m05.amask", 32'(active_mask), 32'h05);
        step(3);
        chk_outs("m05.t4", 6'h05, 6'h00, 1'b1, 1'b0);
        step(10);
        chk_outs("m05.t14", 6'h05, 6'h05, 1'b1, 1'b0);
        step(2);
        chk_outs("m05.t16", 6'h05, 6'h00, 1'b0, 1'b1);

        // "r" in READY.
        send("r");
        chk_outs("r.t1", 6'h05, 6'h05, 1'b1, 1'b0);
        step(1);
        chk_outs("r.t2", 6'h05, 6'h05, 1'b1, 1'b0);
        step(1);
        chk_outs("r.t3", 6'h05, 6'h00, 1'b0, 1'b1);

        // "m" then "h" as mask argument, not a command.
        send("m"); send("h");
        chk("mh.home", 32'(go_home), 0);
        chk_outs("mh.state", 6'h05, 6'h00, 1'b0, 1'b1);

        // "h" during BOOT at count 5.
        send("d");                                     // T+1
        chk("mh.amask", 32'(active_mask), 32'h28);
        step(8);                                       // T+9 = BOOT count 5
        chk_outs("h.boot5", 6'h28, 6'h00, 1'b1, 1'b0);
        send("h");
        chk("h.home", 32'(go_home), 1);
        chk_outs("h.idle", 6'h00, 6'h00, 1'b0, 1'b0);
        send("r");
        chk_outs("r.idle", 6'h00, 6'h00, 1'b0, 1'b0);
        send("d");
        chk("hd.home", 32'(go_home), 0);
        step(3);
        chk_outs("hd.t4", 6'h28, 6'h00, 1'b1, 1'b0);
        step(12);
        chk_outs("hd.t16", 6'h28, 6'h00, 1'b0, 1'b1);

        // Pause toggling during a sequence, then rst in SRST with a pending mask.
        send("d");                                     // T+1
        send("s");                                     // T+2
        chk("s.pause", 32'(pause), 1);
        chk_outs("s.t2", 6'h00, 6'h00, 1'b1, 1'b0);
        send("p");                                     // T+3
        chk("p.pause", 32'(pause), 0);
        step(1);                                       // T+4
        chk_outs("sp.t4", 6'h28, 6'h00, 1'b1, 1'b0);
        step(10);                                      // T+14
        chk_outs("sp.t14", 6'h28, 6'h28, 1'b1, 1'b0);
        send("m");
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_outs("rst", 6'h00, 6'h00, 1'b0, 1'b0);
        chk("rst.amask", 32'(active_mask), 32'h3F);
        send("d");
        chk("rst.pend", 32'(busy), 1);
        step(3);
        chk_outs("rst.cfg", 6'h3F, 6'h00, 1'b1, 1'b0);

        // Zero mask: sequence runs with outputs low, ready still asserts.
        send("m"); send(8'h00); send("d");
        step(13);                                      // T+14
        chk_outs("z.t14", 6'h00, 6'h00, 1'b1, 1'b0);
        step(2);
        chk_outs("z.t16", 6'h00, 6'h00, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
